// File: rtl/rtc_display_refresh_sched.sv
// rtc_display_refresh_sched
//   Once every FRAME_DIV frame_start pulses, reads the eight RTC registers
//   in order (sec, min, hr, date, month, year, weekday, week) into a staging
//   buffer. It then converts all BCD digits to ASCII and updates char_bus in a
//   single commit, so the overlay never sees a half-updated time.
// Ports:
//   clk, rst_n         clock and synchronous active-low reset
//   frame_start        1-cycle pulse at start of vertical blanking
//   rd_req/rd_addr     RTC read request and register index
//   rd_ack/rd_data     RTC acknowledge and packed BCD data (same cycle)
//   char_bus           16 x 7-bit ASCII codes, slot 2k = reg k units, 2k+1 = tens
//   busy               refresh sequence in progress
//   upd_done           1-cycle pulse when char_bus takes new values
//   rd_err             sticky read-timeout flag, cleared by next good commit
module rtc_display_refresh_sched #(
  parameter int unsigned FRAME_DIV = 1,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [6:0]  BAD_CHAR  = 7'h3F
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         frame_start,
  output logic         rd_req,
  output logic [2:0]   rd_addr,
  input  logic         rd_ack,
  input  logic [7:0]   rd_data,
  output logic [111:0] char_bus,
  output logic         busy,
  output logic         upd_done,
  output logic         rd_err
);

  localparam int unsigned NREG = 8;
  localparam int unsigned CW   = 7;
  localparam int unsigned BW   = 2 * NREG * CW;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_NEXT, S_COMMIT, S_ABORT
  } state_e;

  state_e              state_q;
  logic [3:0]          fcnt_q;
  logic                pend_q;
  logic [2:0]          idx_q;
  logic [7:0]          wcnt_q;
  logic [NREG-1:0][7:0] stage_q;
  logic                rd_req_q;
  logic [2:0]          rd_addr_q;
  logic [BW-1:0]       char_q;
  logic                busy_q;
  logic                upd_q;
  logic                err_q;

  logic                trig_c;
  logic [BW-1:0]       conv_c;

  // BCD nibble to ASCII digit; non-decimal nibbles map to BAD_CHAR
  function automatic logic [CW-1:0] cvt(input logic [3:0] n);
    return (n <= 4'd9) ? (7'h30 + 7'(n)) : BAD_CHAR;
  endfunction

  // Frame divider terminal count
  assign trig_c = frame_start && (fcnt_q == 4'(FRAME_DIV - 1));

  // Whole-display conversion from the staging buffer
  always_comb begin
    conv_c = '0;
    for (int unsigned k = 0; k < NREG; k++) begin
      conv_c[2*CW*k      +: CW] = cvt(stage_q[k][3:0]);
      conv_c[2*CW*k + CW +: CW] = cvt(stage_q[k][7:4]);
    end
  end

  // Divider, pending flag and read-sequencing FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      fcnt_q    <= '0;
      pend_q    <= 1'b0;
      idx_q     <= '0;
      wcnt_q    <= '0;
      stage_q   <= '0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      char_q    <= {2*NREG{7'h30}};
      busy_q    <= 1'b0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      upd_q <= 1'b0;

      if (frame_start) begin
        fcnt_q <= trig_c ? 4'd0 : fcnt_q + 4'd1;
      end
      // One-deep pending: triggers during a sequence merge into one rerun
      if (trig_c && (state_q != S_IDLE)) begin
        pend_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (trig_c || pend_q) begin
            state_q   <= S_REQ;
            idx_q     <= '0;
            busy_q    <= 1'b1;
            pend_q    <= 1'b0;
            rd_req_q  <= 1'b1;
            rd_addr_q <= '0;
          end
        end
        S_REQ: begin
          // rd_ack is deliberately not sampled here
          wcnt_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (rd_ack) begin
            stage_q[idx_q] <= rd_data;
            rd_req_q       <= 1'b0;
            state_q        <= (idx_q == 3'(NREG - 1)) ? S_COMMIT : S_NEXT;
          end else if (wcnt_q == 8'(TIMEOUT - 1)) begin
            rd_req_q <= 1'b0;
            state_q  <= S_ABORT;
          end else begin
            wcnt_q <= wcnt_q + 8'd1;
          end
        end
        S_NEXT: begin
          idx_q     <= idx_q + 3'd1;
          rd_addr_q <= idx_q + 3'd1;
          rd_req_q  <= 1'b1;
          state_q   <= S_REQ;
        end
        S_COMMIT: begin
          char_q  <= conv_c;
          upd_q   <= 1'b1;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_ABORT: begin
          // Partial staging is simply overwritten by the next full sequence
          err_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_req   = rd_req_q;
  assign rd_addr  = rd_addr_q;
  assign char_bus = char_q;
  assign busy     = busy_q;
  assign upd_done = upd_q;
  assign rd_err   = err_q;

endmodule

// File: tb/tb_rtc_display_refresh_sched.sv
// Bench for rtc_display_refresh_sched: a FRAME_DIV=1/TIMEOUT=8 instance with a
// scripted RTC responder, plus a FRAME_DIV=3 instance for the divider check.
module tb_rtc_display_refresh_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         frame_start;
  logic         rd_req;
  logic [2:0]   rd_addr;
  logic         rd_ack;
  logic [7:0]   rd_data;
  logic [111:0] char_bus;
  logic         busy, upd_done, rd_err;

  logic         fs_b;
  logic         rd_req_b;
  logic [2:0]   rd_addr_b;
  logic         rd_ack_b;
  logic [7:0]   rd_data_b;
  logic [111:0] char_bus_b;
  logic         busy_b, upd_done_b, rd_err_b;

  logic [7:0]   mem [8];
  logic         stall_en;
  logic [2:0]   stall_addr;

  logic [111:0] exp_q [$];
  logic [111:0] last_exp;
  int           n_vec = 0;
  int           n_err = 0;

  typedef struct {
    logic [63:0] regs;
    int          sa;
    logic [6:0]  va;
    int          sb;
    logic [6:0]  vb;
  } vec_t;
  vec_t vt [4];

  always #5 clk = ~clk;

  // RTC responder: acks in the same cycle as rd_req unless stalled on one address
  assign rd_ack    = rd_req && !(stall_en && (rd_addr == stall_addr));
  assign rd_data   = mem[rd_addr];
  assign rd_ack_b  = rd_req_b;
  assign rd_data_b = 8'h42;

  rtc_display_refresh_sched #(.FRAME_DIV(1), .TIMEOUT(8), .BAD_CHAR(7'h3F)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .char_bus(char_bus), .busy(busy), .upd_done(upd_done), .rd_err(rd_err)
  );

  rtc_display_refresh_sched #(.FRAME_DIV(3), .TIMEOUT(8), .BAD_CHAR(7'h3F)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_start(fs_b),
    .rd_req(rd_req_b), .rd_addr(rd_addr_b), .rd_ack(rd_ack_b), .rd_data(rd_data_b),
    .char_bus(char_bus_b), .busy(busy_b), .upd_done(upd_done_b), .rd_err(rd_err_b)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference conversion: digit nibbles become '0'..'9', anything else '?'
  function automatic logic [111:0] exp_bus(input logic [63:0] regs);
    logic [111:0] b;
    logic [7:0]   byt;
    logic [3:0]   nib;
    b = '0;
    for (int s = 0; s < 16; s++) begin
      byt = regs[8*(s/2) +: 8];
      nib = (s % 2 == 1) ? byt[7:4] : byt[3:0];
      b[7*s +: 7] = (nib < 4'd10) ? 7'(8'd48 + 8'(nib)) : 7'h3F;
    end
    return b;
  endfunction

  function automatic logic [6:0] slot(input logic [111:0] b, input int s);
    return b[7*s +: 7];
  endfunction

  task automatic load_mem(input logic [63:0] regs);
    for (int k = 0; k < 8; k++) mem[k] = regs[8*k +: 8];
  endtask

  task automatic pulse_a();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  // Waits for upd_done; lat counts negedges starting at the cycle after the pulse
  task automatic wait_upd(input int max, output int lat);
    lat = 0;
    for (int k = 1; k <= max; k++) begin
      @(negedge clk);
      if (upd_done) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) chk("upd_timeout", 128'(upd_done), 128'(1'b1));
    @(posedge clk); #1;
  endtask

  task automatic find_req(input logic [2:0] a, input string nm);
    bit found = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (rd_req && rd_addr == a) begin
        found = 1;
        break;
      end
    end
    if (!found) chk(nm, 128'(rd_req), 128'(1'b1));
  endtask

  // Scoreboard: every upd_done pops one expected display image
  always @(negedge clk) begin
    if (rst_n && upd_done) begin
      if (exp_q.size() == 0) chk("upd_unexpected", 128'(upd_done), 128'(1'b0));
      else chk("char_bus", 128'(char_bus), 128'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int lat, hi, cu, cr;
    logic [111:0] e;

    vt[0] = '{64'h52_06_99_12_31_23_07_59, 0, 7'h39, 1, 7'h35};
    vt[1] = '{64'h01_00_00_01_01_00_00_00, 6, 7'h31, 7, 7'h30};
    vt[2] = '{64'h27_03_A3_08_15_11_30_45, 10, 7'h33, 11, 7'h3F};
    vt[3] = '{64'h00_00_00_00_00_00_9A_FF, 2, 7'h3F, 3, 7'h39};

    rst_n = 1'b0; frame_start = 1'b0; fs_b = 1'b0;
    stall_en = 1'b0; stall_addr = 3'd0;
    load_mem(64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_char_bus", 128'(char_bus), 128'({16{7'h30}}));
    chk("rst_rd_req",   128'(rd_req),   128'(1'b0));
    chk("rst_rd_addr",  128'(rd_addr),  128'(3'd0));
    chk("rst_busy",     128'(busy),     128'(1'b0));
    chk("rst_upd_done", 128'(upd_done), 128'(1'b0));
    chk("rst_rd_err",   128'(rd_err),   128'(1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_exp = {16{7'h30}};

    // Divide-by-3: only every third frame_start launches a sequence
    for (int p = 0; p < 6; p++) begin
      fs_b = 1'b1;
      @(posedge clk); #1;
      fs_b = 1'b0;
      cu = 0; cr = 0;
      repeat (39) begin
        @(negedge clk);
        if (upd_done_b) cu++;
        if (rd_req_b) cr++;
      end
      @(posedge clk); #1;
      chk("div3_upd", 128'(cu), 128'((p % 3 == 2) ? 1 : 0));
      chk("div3_req", 128'(cr != 0), 128'(p % 3 == 2));
    end
    chk("div3_bus", 128'(slot(char_bus_b, 1)), 128'(7'h34));

    // Table-driven full refresh sequences
    for (int i = 0; i < 4; i++) begin
      load_mem(vt[i].regs);
      e = exp_bus(vt[i].regs);
      exp_q.push_back(e);
      pulse_a();
      wait_upd(60, lat);
      last_exp = e;
      chk($sformatf("v%0d_slot%0d", i, vt[i].sa), 128'(slot(char_bus, vt[i].sa)), 128'(vt[i].va));
      chk($sformatf("v%0d_slot%0d", i, vt[i].sb), 128'(slot(char_bus, vt[i].sb)), 128'(vt[i].vb));
      chk("seq_busy_after", 128'(busy), 128'(1'b0));
      if (i == 0) begin
        chk("latency", 128'(lat), 128'(25));
        chk("v0_slot2", 128'(slot(char_bus, 2)), 128'(7'h37));
        chk("v0_slot3", 128'(slot(char_bus, 3)), 128'(7'h30));
        chk("v0_slot4", 128'(slot(char_bus, 4)), 128'(7'h33));
        chk("v0_slot5", 128'(slot(char_bus, 5)), 128'(7'h32));
      end
    end

    // Timeout on month register: req high for REQ + 8 WAIT cycles, then abort
    stall_en = 1'b1; stall_addr = 3'd4;
    load_mem(vt[1].regs);
    pulse_a();
    find_req(3'd4, "to_find_req");
    hi = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rd_req) hi++;
      else break;
    end
    chk("to_req_cycles", 128'(hi), 128'(9));
    repeat (2) @(negedge clk);
    chk("to_rd_err",   128'(rd_err),   128'(1'b1));
    chk("to_busy",     128'(busy),     128'(1'b0));
    chk("to_char_bus", 128'(char_bus), 128'(last_exp));
    @(posedge clk); #1;
    stall_en = 1'b0;
    e = exp_bus(vt[1].regs);
    exp_q.push_back(e);
    pulse_a();
    wait_upd(60, lat);
    last_exp = e;
    chk("to_err_cleared", 128'(rd_err), 128'(1'b0));

    // Two triggers during one sequence merge into exactly one rerun
    load_mem(vt[2].regs);
    e = exp_bus(vt[2].regs);
    exp_q.push_back(e);
    exp_q.push_back(e);
    pulse_a();
    repeat (5) @(posedge clk); #1;
    pulse_a();
    repeat (3) @(posedge clk); #1;
    pulse_a();
    cu = 0;
    repeat (120) begin
      @(negedge clk);
      if (upd_done) cu++;
    end
    @(posedge clk); #1;
    last_exp = e;
    chk("pend_upd_count", 128'(cu), 128'(2));
    chk("pend_idle", 128'(busy), 128'(1'b0));

    // Reset while waiting on the year register aborts without commit
    load_mem(vt[0].regs);
    pulse_a();
    find_req(3'd5, "rst_find_req");
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_rd_req",   128'(rd_req),   128'(1'b0));
    chk("midrst_busy",     128'(busy),     128'(1'b0));
    chk("midrst_char_bus", 128'(char_bus), 128'({16{7'h30}}));
    chk("midrst_upd",      128'(upd_done), 128'(1'b0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    cu = 0;
    repeat (40) begin
      @(negedge clk);
      if (upd_done) cu++;
    end
    chk("midrst_no_commit", 128'(cu), 128'(0));
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
